// File: rtl/uart_rx_pkg.sv
// Shared types and default sizes for the UART receive FIFO slice.
package uart_rx_pkg;

  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_TOUT_W = 16;

  // One stored receive byte with its frame/parity error flag
  typedef struct packed {
    logic                  err;
    logic [DEF_DATA_W-1:0] data;
  } rx_entry_t;

  // Receive-timeout counter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } tout_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_timeout.sv
// Receive-timeout counter: flags a non-empty FIFO that has seen no push or pop
// for tout_val_i cycles. Built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_timeout
  import uart_rx_pkg::*;
#(
  parameter int unsigned TOUT_W = DEF_TOUT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [TOUT_W-1:0] tout_val_i,
  input  logic              push_acc_i,
  input  logic              pop_acc_i,
  input  logic              empty_next_i,
  input  logic              fifo_clr_i,
  output logic              intr_timeout
);

  tout_state_e       state;
  logic [TOUT_W-1:0] cnt;

  // Timeout FSM, counter and registered interrupt. The empty check uses the
  // post-edge occupancy so the count starts on the edge that stores the byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      intr_timeout <= 1'b0;
    end else if (fifo_clr_i || empty_next_i || (tout_val_i == '0)) begin
      state        <= IDLE;
      cnt          <= '0;
      intr_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state        <= COUNT;
          cnt          <= '0;
          intr_timeout <= 1'b0;
        end
        COUNT: begin
          if (push_acc_i || pop_acc_i) begin
            cnt <= '0;
          end else if (cnt >= (tout_val_i - TOUT_W'(1))) begin
            state        <= FIRED;
            intr_timeout <= 1'b1;
          end else begin
            cnt <= cnt + TOUT_W'(1);
          end
        end
        FIRED: begin
          if (push_acc_i || pop_acc_i) begin
            state        <= COUNT;
            cnt          <= '0;
            intr_timeout <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          intr_timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_rx_timeout

// File: rtl/uart_fifo_rx.sv
// UART receive FIFO: buffers received bytes with per-byte error flags, exposes
// occupancy/full/empty/threshold flags and a sticky overrun flag.
// Optional receive timeout (tout_val_i, intr_timeout, TOUT_W) is built when
// the macro UART_RX_TIMEOUT_EN is defined.
module uart_fifo_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
`ifdef UART_RX_TIMEOUT_EN
  ,
  parameter int unsigned TOUT_W = DEF_TOUT_W
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_W-1:0]        rx_data_i,
  input  logic                     rx_valid_i,
  input  logic                     rx_err_i,
  input  logic                     rd_en,
  input  logic                     fifo_clr_i,
  input  logic                     ovr_clr_i,
  input  logic [2:0]               intr_blevel,
  output logic [DATA_W-1:0]        data_o,
  output logic                     data_err_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     intr_full,
  output logic                     intr_empty,
  output logic                     intr_level,
  output logic                     intr_overrun
`ifdef UART_RX_TIMEOUT_EN
  ,
  input  logic [TOUT_W-1:0]        tout_val_i,
  output logic                     intr_timeout
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;
  logic [DATA_W:0] mem [DEPTH];

  logic full_c;
  logic empty_c;
  logic push_acc;
  logic pop_acc;
  logic ovr_set;

  // Accept/drop decisions and next pointer values; a flush discards both sides
  always_comb begin
    empty_c  = (wr_ptr == rd_ptr);
    full_c   = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    pop_acc  = rd_en && !empty_c && !fifo_clr_i;
    push_acc = rx_valid_i && !fifo_clr_i && (!full_c || pop_acc);
    ovr_set  = rx_valid_i && !fifo_clr_i && full_c && !pop_acc;
    wr_ptr_n = wr_ptr + PW'(push_acc);
    rd_ptr_n = rd_ptr + PW'(pop_acc);
    if (fifo_clr_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end
  end

  // Status flags derived directly from the pointers
  always_comb begin
    level_o    = wr_ptr - rd_ptr;
    intr_full  = full_c;
    intr_empty = empty_c;
    intr_level = (intr_blevel != 3'd0) && (32'(level_o) >= 32'(intr_blevel));
  end

  // Read and write pointers with wrap bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
    end
  end

  // Entry storage; contents need no reset
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[wr_ptr[AW-1:0]] <= {rx_err_i, rx_data_i};
    end
  end

  // Registered head byte and one-cycle read-valid pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o     <= '0;
      data_err_o <= 1'b0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= pop_acc;
      if (pop_acc) begin
        {data_err_o, data_o} <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Sticky overrun; a new drop wins over a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_overrun <= 1'b0;
    end else if (ovr_set) begin
      intr_overrun <= 1'b1;
    end else if (ovr_clr_i) begin
      intr_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic empty_next;

  // Occupancy after the current edge, used to start and stop the timeout
  always_comb begin
    empty_next = (wr_ptr_n == rd_ptr_n);
  end

  uart_rx_timeout #(
    .TOUT_W (TOUT_W)
  ) u_timeout (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tout_val_i   (tout_val_i),
    .push_acc_i   (push_acc),
    .pop_acc_i    (pop_acc),
    .empty_next_i (empty_next),
    .fifo_clr_i   (fifo_clr_i),
    .intr_timeout (intr_timeout)
  );
`endif

endmodule : uart_fifo_rx

// File: doc/uart_fifo_rx.md
Name: uart_fifo_rx

Overview:
Receive-side buffer of the UART peripheral. Written by the UART receiver shift logic, one byte per accepted frame, with a per-byte error flag. Read by the bus/register interface. Provides occupancy, full, empty, threshold and overrun interrupt flags for the interrupt controller, and a sticky overrun indication.

Parameters:
DEPTH, 8, number of entries; power of two, minimum 2
DATA_W, 8, byte width
TOUT_W, 16, width of the receive-timeout counter (used only with the optional feature)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset; asynchronous assert, active-low
rx_data_i  input  DATA_W  byte from the receiver
rx_valid_i  input  1  single-cycle strobe; rx_data_i/rx_err_i are valid
rx_err_i  input  1  frame or parity error for this byte
rd_en  input  1  pop request from the bus side
fifo_clr_i  input  1  synchronous flush
ovr_clr_i  input  1  clears the sticky overrun flag
intr_blevel  input  3  threshold level; 0 disables the threshold interrupt
data_o  output  DATA_W  registered head byte from the last accepted pop
data_err_o  output  1  error flag stored with data_o
rd_valid_o  output  1  one-cycle pulse; data_o was updated this cycle
level_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
intr_full  output  1  level_o == DEPTH
intr_empty  output  1  level_o == 0
intr_level  output  1  (intr_blevel != 0) && (level_o >= intr_blevel)
intr_overrun  output  1  sticky; a byte was dropped

Behaviour:
- Storage: DEPTH entries of {err, data}.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - level_o = wr_ptr - rd_ptr, modulo 2^(ptr width).
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
- Flags: intr_full, intr_empty, intr_level and level_o are combinational from the pointers. Registered outputs change only on clk_i.
- Reset values (async, rst_ni low): pointers 0; data_o 0; data_err_o 0; rd_valid_o 0; intr_overrun 0. Resulting flags: level_o 0, intr_empty 1, intr_full 0, intr_level 0. Memory contents are don't-care.
- Push: accepted when rx_valid_i=1 and (not full, or a pop is accepted in the same cycle). Entry is written at wr_ptr, and wr_ptr increments.
- Pop: accepted when rd_en=1 and not empty. Effects in the next cycle:
  - data_o and data_err_o take the entry at rd_ptr;
  - rd_ptr increments;
  - rd_valid_o=1 for exactly one cycle.
  - Read latency is 1 clock.
- Pop when empty: ignored. data_o holds its value and rd_valid_o stays 0. A push in the same cycle is not bypassed to data_o.
- Simultaneous push and pop when full: both are accepted, the level is unchanged, and no overrun.
- Simultaneous push and pop at intermediate levels: both are accepted, and the level is unchanged.
- Push when full without a pop: the byte is dropped, pointers are unchanged, and intr_overrun is set on the next edge.
- Overrun flag:
  - Remains set until a cycle with ovr_clr_i=1.
  - If ovr_clr_i and a new overrun occur in the same cycle, the set wins.
  - fifo_clr_i does not affect intr_overrun.
- fifo_clr_i: highest priority apart from reset. Both pointers go to 0, and any push or pop in that cycle is discarded. rd_valid_o is 0 next cycle. data_o and data_err_o hold their values.
- Wrap-around: pointers roll over naturally modulo 2^(ptr width). Data order is preserved across the wrap.
- Mid-operation reset: everything returns to the reset values immediately. No partial pop is reported.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- When defined:
  - Adds input tout_val_i [TOUT_W], output intr_timeout, and a counter FSM with states IDLE, COUNT and FIRED.
  - IDLE -> COUNT: when the FIFO is non-empty. The counter loads 0.
  - In COUNT: the counter increments each cycle. It resets to 0 on any accepted push or pop.
  - COUNT -> FIRED: when count == tout_val_i - 1. intr_timeout=1 while in FIRED.
  - FIRED -> COUNT: on an accepted pop that leaves the FIFO non-empty, or on an accepted push.
  - Any state -> IDLE: when the FIFO becomes empty or fifo_clr_i is asserted.
  - tout_val_i==0 disables the feature: the FSM stays in IDLE.
- When not defined: the ports are absent and the logic is not built.

Decomposition:
- Package uart_rx_pkg:
  - DEPTH/DATA_W defaults;
  - typedef rx_entry_t packed struct {logic err; logic [DATA_W-1:0] data};
  - typedef tout_state_e {IDLE, COUNT, FIRED}.
- Sub-module uart_rx_timeout contains the optional timeout FSM and counter. It is instantiated only under UART_RX_TIMEOUT_EN.

Test Plan:
1. Reset, then push 0xA5 (err=0) and 0x3C (err=1), then pop twice.
   - Response: data_o=0xA5/err 0, then 0x3C/err 1.
   - rd_valid_o pulses one cycle after each rd_en.
   - intr_empty=1 at the end.
2. Push 8 bytes 0x01..0x08, then push 0x09.
   - Response: intr_full=1 and level_o=8.
   - 0x09 is dropped and intr_overrun=1.
   - Popping all 8 returns 0x01..0x08.
   - ovr_clr_i clears the overrun flag.
3. At full, push 0x55 and pop in the same cycle.
   - Response: level stays 8 and no overrun.
   - The 8th subsequent pop returns 0x55.
4. intr_blevel=3: push 2 bytes, then 1 more.
   - Response: intr_level goes 0 -> 1 on the 3rd push.
   - A pop returns it to 0.
   - Repeat with intr_blevel=0: intr_level stays 0.
5. Run 20 push/pop pairs across the pointer wrap, with fifo_clr_i asserted alongside a push at level 5.
   - Response: order is preserved before the clear.
   - After the clear, level_o=0 and data_o is unchanged.
6. With UART_RX_TIMEOUT_EN, tout_val_i=10: push 1 byte, then idle.
   - Response: intr_timeout=1 exactly 10 cycles after the push.
   - A pop clears it, and the FSM returns to IDLE.
